// File: rtl/bomb_countdown_ctrl_if.sv
// Handshake bundle between the game FSM / time table / display path and the
// bomb countdown controller.
interface bomb_countdown_ctrl_if;
  logic       start;
  logic       level_clear;
  logic       pause;
  logic [3:0] tbl_three;
  logic [3:0] tbl_two;
  logic [3:0] tbl_one;
  logic [7:0] game_level;
  logic [3:0] digit_three;
  logic [3:0] digit_two;
  logic [3:0] digit_one;
  logic       running;
  logic       level_up;
  logic       boom;

  modport master (
    output start, level_clear, pause, tbl_three, tbl_two, tbl_one,
    input  game_level, digit_three, digit_two, digit_one, running, level_up, boom
  );

  modport slave (
    input  start, level_clear, pause, tbl_three, tbl_two, tbl_one,
    output game_level, digit_three, digit_two, digit_one, running, level_up, boom
  );
endinterface

// File: rtl/bomb_countdown_ctrl.sv
// Per-level bomb timer: owns the game level, loads three BCD digits from the
// registered time table and counts them down once per second.
module bomb_countdown_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MAX_LEVEL     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  bomb_countdown_ctrl_if.slave  ctrl
);

  localparam int                PRESC_W    = $clog2(TICKS_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]        LEVEL_MAX  = 8'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         level_q, level_d;
  logic [3:0]         three_q, three_d;
  logic [3:0]         two_q, two_d;
  logic [3:0]         one_q, one_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               settle_q, settle_d;
  logic               level_up_q, level_up_d;
  logic               boom_q, boom_d;

  logic [3:0] dec_three, dec_two, dec_one;
  logic       borrow_one, borrow_two;
  logic       is_zero, dec_zero;
  logic [7:0] level_inc;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // BCD decrement with borrow; only used when the value is non-zero
  always_comb begin
    borrow_one = (one_q == 4'd0);
    borrow_two = borrow_one && (two_q == 4'd0);
    dec_one    = borrow_one ? 4'd9 : (one_q - 4'd1);
    if (borrow_one) begin
      dec_two = (two_q == 4'd0) ? 4'd9 : (two_q - 4'd1);
    end else begin
      dec_two = two_q;
    end
    dec_three = borrow_two ? (three_q - 4'd1) : three_q;
  end

  assign is_zero   = (three_q == 4'd0) && (two_q == 4'd0) && (one_q == 4'd0);
  assign dec_zero  = (dec_three == 4'd0) && (dec_two == 4'd0) && (dec_one == 4'd0);
  assign level_inc = (level_q >= LEVEL_MAX) ? LEVEL_MAX : (level_q + 8'd1);

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    three_d    = three_q;
    two_d      = two_q;
    one_d      = one_q;
    presc_d    = presc_q;
    settle_d   = settle_q;
    level_up_d = 1'b0;
    boom_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl.start) begin
          level_d  = 8'd0;
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end
      end

      // Second cycle sees table data for the level set on SETTLE entry
      S_SETTLE: begin
        if (settle_q) begin
          three_d = clamp9(ctrl.tbl_three);
          two_d   = clamp9(ctrl.tbl_two);
          one_d   = clamp9(ctrl.tbl_one);
          presc_d = '0;
          state_d = S_RUN;
        end else begin
          settle_d = 1'b1;
        end
      end

      S_RUN, S_PAUSED: begin
        if (ctrl.start) begin
          level_d  = 8'd0;
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end else if (ctrl.level_clear) begin
          level_up_d = 1'b1;
          level_d    = level_inc;
          settle_d   = 1'b0;
          state_d    = S_SETTLE;
        end else if (state_q == S_RUN) begin
          if (is_zero) begin
            boom_d  = 1'b1;
            state_d = S_EXPIRED;
          end else if (ctrl.pause) begin
            state_d = S_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            three_d = dec_three;
            two_d   = dec_two;
            one_d   = dec_one;
            if (dec_zero) begin
              boom_d  = 1'b1;
              state_d = S_EXPIRED;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end else if (!ctrl.pause) begin
          state_d = S_RUN;
        end
      end

      S_EXPIRED: begin
        if (ctrl.start) begin
          level_d  = 8'd0;
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      level_q    <= 8'd0;
      three_q    <= 4'd0;
      two_q      <= 4'd0;
      one_q      <= 4'd0;
      presc_q    <= '0;
      settle_q   <= 1'b0;
      level_up_q <= 1'b0;
      boom_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      three_q    <= three_d;
      two_q      <= two_d;
      one_q      <= one_d;
      presc_q    <= presc_d;
      settle_q   <= settle_d;
      level_up_q <= level_up_d;
      boom_q     <= boom_d;
    end
  end

  assign ctrl.game_level  = level_q;
  assign ctrl.digit_three = three_q;
  assign ctrl.digit_two   = two_q;
  assign ctrl.digit_one   = one_q;
  assign ctrl.running     = (state_q == S_RUN);
  assign ctrl.level_up    = level_up_q;
  assign ctrl.boom        = boom_q;

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
// Directed bench for bomb_countdown_ctrl with a registered time-table model
// (TICKS_PER_SEC = 4).
module tb_bomb_countdown_ctrl;

  logic clk;
  logic reset;
  int   passes = 0;
  int   total  = 0;

  bomb_countdown_ctrl_if bus_if();

  bomb_countdown_ctrl #(
    .TICKS_PER_SEC (4),
    .MAX_LEVEL     (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time table contents, as BCD nibbles; level 4 deliberately out of range
  function automatic logic [11:0] table_value(input logic [7:0] lvl);
    case (lvl)
      8'd0:    return 12'h200;
      8'd1:    return 12'h100;
      8'd2:    return 12'h060;
      8'd4:    return 12'hFA3;
      8'd5:    return 12'h000;
      default: return 12'h150;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [11:0] v;
    v = table_value(bus_if.game_level);
    bus_if.tbl_three <= v[11:8];
    bus_if.tbl_two   <= v[7:4];
    bus_if.tbl_one   <= v[3:0];
  end

  logic [11:0] digits;
  assign digits = {bus_if.digit_three, bus_if.digit_two, bus_if.digit_one};

  function automatic logic [11:0] bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse level_clear from RUN and step to the first RUN cycle of the new level
  task automatic load_next();
    bus_if.level_clear = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.level_clear = 1'b0;
    bus_if.pause       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", bus_if.game_level, 0);
    chk("rst_digits", digits, 0);
    chk("rst_running", bus_if.running, 0);
    chk("rst_level_up", bus_if.level_up, 0);
    chk("rst_boom", bus_if.boom, 0);
    reset = 1'b0;
    tick();

    $display("step: idle ignores level_clear/pause");
    bus_if.level_clear = 1'b1;
    bus_if.pause       = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    bus_if.pause       = 1'b0;
    tick();
    chk("idle_level", bus_if.game_level, 0);
    chk("idle_level_up", bus_if.level_up, 0);
    chk("idle_running", bus_if.running, 0);

    $display("step: start, load 200, borrow chain");
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk("settle1_running", bus_if.running, 0);
    tick();
    chk("settle2_running", bus_if.running, 0);
    tick();
    chk("load200_digits", digits, 12'h200);
    chk("load200_running", bus_if.running, 1);
    repeat (3) tick();
    chk("pretick_digits", digits, 12'h200);
    tick();
    chk("borrow_digits", digits, 12'h199);

    $display("step: level_clear mid-count at level 0");
    tick();
    bus_if.level_clear = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    chk("clr_level_up", bus_if.level_up, 1);
    chk("clr_level", bus_if.game_level, 1);
    chk("clr_running", bus_if.running, 0);
    chk("clr_digits_hold", digits, 12'h199);
    tick();
    chk("clr_level_up_end", bus_if.level_up, 0);
    tick();
    chk("lvl1_digits", digits, 12'h100);
    chk("lvl1_running", bus_if.running, 1);

    $display("step: level 2 full countdown from 060");
    load_next();
    chk("lvl2_level", bus_if.game_level, 2);
    chk("lvl2_digits", digits, 12'h060);
    for (int n = 59; n >= 1; n--) begin
      repeat (4) tick();
      chk("count_digits", digits, bcd(n));
      chk("count_boom", bus_if.boom, 0);
    end
    repeat (4) tick();
    chk("expire_digits", digits, 12'h000);
    chk("expire_boom", bus_if.boom, 1);
    chk("expire_running", bus_if.running, 0);
    tick();
    chk("expire_boom_end", bus_if.boom, 0);
    bus_if.level_clear = 1'b1;
    bus_if.pause       = 1'b1;
    repeat (8) tick();
    bus_if.level_clear = 1'b0;
    bus_if.pause       = 1'b0;
    chk("expired_digits", digits, 12'h000);
    chk("expired_running", bus_if.running, 0);
    chk("expired_level", bus_if.game_level, 2);
    chk("expired_boom", bus_if.boom, 0);

    $display("step: level_clear on the final tick");
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    chk("restart_digits", digits, 12'h200);
    chk("restart_level", bus_if.game_level, 0);
    load_next();
    load_next();
    chk("relvl2_digits", digits, 12'h060);
    repeat (59 * 4) tick();
    chk("final_pre_digits", digits, 12'h001);
    repeat (3) tick();
    bus_if.level_clear = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    chk("final_boom", bus_if.boom, 0);
    chk("final_level_up", bus_if.level_up, 1);
    chk("final_level", bus_if.game_level, 3);
    chk("final_digits_hold", digits, 12'h001);
    tick();
    chk("final_boom_after", bus_if.boom, 0);
    tick();
    chk("lvl3_digits", digits, 12'h150);
    chk("lvl3_running", bus_if.running, 1);

    $display("step: pause for 10 cycles after 2 prescaler counts");
    repeat (2) tick();
    bus_if.pause = 1'b1;
    tick();
    chk("pause_running", bus_if.running, 0);
    repeat (9) tick();
    chk("pause_digits", digits, 12'h150);
    chk("pause_running_end", bus_if.running, 0);
    bus_if.pause = 1'b0;
    tick();
    chk("resume_running", bus_if.running, 1);
    chk("resume_digits", digits, 12'h150);
    tick();
    chk("resume_digits_1", digits, 12'h150);
    tick();
    chk("resume_digits_2", digits, 12'h149);

    $display("step: level_clear while paused, clamped load");
    bus_if.pause = 1'b1;
    tick();
    bus_if.level_clear = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    chk("pclr_level_up", bus_if.level_up, 1);
    chk("pclr_level", bus_if.game_level, 4);
    bus_if.pause = 1'b0;
    tick();
    tick();
    chk("clamp_digits", digits, 12'h993);
    chk("clamp_running", bus_if.running, 1);

    $display("step: zero load expires without decrement");
    load_next();
    chk("zero_digits", digits, 12'h000);
    chk("zero_running", bus_if.running, 1);
    chk("zero_boom_pre", bus_if.boom, 0);
    tick();
    chk("zero_boom", bus_if.boom, 1);
    chk("zero_running_after", bus_if.running, 0);
    chk("zero_digits_after", digits, 12'h000);
    tick();
    chk("zero_boom_end", bus_if.boom, 0);

    $display("step: asynchronous reset mid-run");
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    load_next();
    tick();
    chk("prereset_level", bus_if.game_level, 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_level", bus_if.game_level, 0);
    chk("areset_digits", digits, 0);
    chk("areset_running", bus_if.running, 0);
    bus_if.start = 1'b1;
    tick();
    chk("reset_start_running", bus_if.running, 0);
    chk("reset_start_digits", digits, 0);
    reset        = 1'b0;
    bus_if.start = 1'b0;
    tick();
    tick();
    chk("post_reset_running", bus_if.running, 0);
    chk("post_reset_digits", digits, 0);

    $display("step: level saturation at 255");
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 255; i++) begin
      load_next();
    end
    chk("sat_level", bus_if.game_level, 255);
    chk("sat_running", bus_if.running, 1);
    bus_if.level_clear = 1'b1;
    tick();
    bus_if.level_clear = 1'b0;
    chk("sat_level_up", bus_if.level_up, 1);
    chk("sat_level_hold", bus_if.game_level, 255);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/bomb_countdown_ctrl.md
Name: bomb_countdown_ctrl

Overview:
- Sequences the per-level bomb timer: owns the current game level and drives it to the level-to-time lookup table.
- Loads the returned three BCD digits and counts them down once per second.
- Reports defuse and expiry events to the game FSM and provides live digits to the 7-segment display path.
- Sits between the game FSM and the time lookup table and display driver.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second decrement; minimum 2, sim uses 4.
- MAX_LEVEL, 255, level saturation value; must be ≤ 255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new game at level 0
- level_clear  in  1  one-cycle pulse; player defused current level
- pause  in  1  level-sensitive; freezes countdown while high
- tbl_three  in  4  hundreds digit returned by time table (registered table, 1-cycle latency)
- tbl_two  in  4  tens digit from time table
- tbl_one  in  4  ones digit from time table
- game_level  out  8  current level, drives time table input
- digit_three  out  4  live hundreds digit (BCD)
- digit_two  out  4  live tens digit (BCD)
- digit_one  out  4  live ones digit (BCD)
- running  out  1  high while state is RUN
- level_up  out  1  one-cycle pulse when a level is cleared
- boom  out  1  one-cycle pulse when timer reaches 000

Behaviour:
- Reset (async, any time, incl. mid-count):
  - State IDLE; game_level=0; all digits=0; prescaler=0.
  - running, level_up, boom all 0.
- States: IDLE, SETTLE, RUN, PAUSED, EXPIRED.
- IDLE:
  - start → game_level=0, settle counter=0, go SETTLE.
  - level_clear and pause ignored.
- SETTLE (exactly 2 cycles): covers the table's registered latency after game_level changes.
  - On the 2nd cycle, capture tbl_* into digit_*; any tbl digit >9 is clamped to 9.
  - prescaler=0, go RUN.
  - Inputs other than reset are ignored in SETTLE.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap (tick), the 3-digit BCD value decrements by 1 with borrow: ones 0→9 borrows from tens; tens 0→9 borrows from hundreds.
  - Tick that produces 000 → boom=1 for that next cycle, go EXPIRED.
  - pause high → go PAUSED; prescaler holds its value, no decrement that cycle.
  - level_clear → level_up pulse (1 cycle), game_level = min(game_level+1, MAX_LEVEL), go SETTLE; digits hold until reload.
  - level_clear has priority over pause and over a same-cycle tick, including the final tick to 000. No boom in that case.
  - start in RUN restarts: game_level=0, go SETTLE.
- PAUSED:
  - Digits and prescaler frozen.
  - pause low → return to RUN and resume prescaler from held value.
  - level_clear in PAUSED is honoured exactly as in RUN.
  - start restarts as in RUN.
- EXPIRED:
  - Digits stay 000; running=0.
  - Only start leaves EXPIRED (→ SETTLE, level 0).
- running = (state==RUN); 0 in PAUSED, SETTLE, IDLE, EXPIRED.
- Loaded value 000 from the table → first RUN cycle detects zero, boom pulses, go EXPIRED, no decrement.
- Digits update only on tick or load; level_up and boom never assert in the same cycle.
- Prescaler width = ceil(log2(TICKS_PER_SEC)).

Test Plan (TICKS_PER_SEC=4, table model returns level0=200, level1=100, level2=060, registered):
- Reset, then start → after 2 SETTLE cycles digits=2,0,0, running=1; 4 cycles later digits=1,9,9 (borrow chain).
- Level 2 loaded as 060, run 60 ticks → digits step 059…001, then 000 with boom high exactly one cycle; state EXPIRED, running=0; later ticks cause no change.
- level_clear at level 0 mid-count → level_up 1 cycle, game_level=1, 2 cycles later digits=1,0,0 and running=1.
- level_clear in the same cycle as the final tick to 000 → no boom, level_up=1, next level loads.
- pause high for 10 cycles after 2 prescaler counts → digits frozen; after pause low, next decrement occurs exactly 2 cycles later.
- Assert reset asynchronously mid-RUN (between clk edges) → all outputs 0 immediately, IDLE. start ignored while reset high. Saturation: force level 255, then level_clear → game_level stays 255.
